// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
//  Module      : id_ex_stage_pkg
//  Description : Shared ALU op codes, main-control ALU classes, R-type funct
//                values and the ID/EX control bundle type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

   // 3-bit op codes understood by the ALU
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_MUL = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;

   // Main-control ALU class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // Supported R-type funct values
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;

   // Control bits carried through the pipeline register; a bubble is all zero
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic illegal;
   } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_alu_control.sv
// ============================================================================
//  Module      : id_ex_stage_alu_control
//  Description : Combinational ALU control. Maps the main-control ALU class
//                and the R-type funct field onto the 3-bit ALU op code and
//                flags R-type funct values the ALU does not implement.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage_alu_control
   import id_ex_stage_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_op,
   output logic       o_illegal
);

   // Decode class/funct; unknown funct falls back to ADD and raises illegal
   always_comb begin
      o_alu_op  = ALU_ADD;
      o_illegal = 1'b0;
      case (i_alu_op)
         ALUOP_ADD: o_alu_op = ALU_ADD;
         ALUOP_SUB: o_alu_op = ALU_SUB;
         ALUOP_OR:  o_alu_op = ALU_OR;
         default: begin
            case (i_funct)
               FUNCT_ADD: o_alu_op = ALU_ADD;
               FUNCT_SUB: o_alu_op = ALU_SUB;
               FUNCT_MUL: o_alu_op = ALU_MUL;
               FUNCT_AND: o_alu_op = ALU_AND;
               FUNCT_OR:  o_alu_op = ALU_OR;
               default: begin
                  o_alu_op  = ALU_ADD;
                  o_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register plus EX operand preparation.
//                Captures operands/controls from ID, decodes the ALU op,
//                forwards from EX/MEM and MEM/WB and applies the ALUSrc mux.
//                Flush inserts a bubble (beats stall); stall holds everything.
//  Config      : define FORWARDING_EN to enable the forwarding muxes; without
//                it the operands come straight from the registered reg-file
//                values and the exmem_*/memwb_* ports are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] rs_data_i,
   input  logic [DATA_WIDTH-1:0] rt_data_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
   input  logic [REG_ADDR_W-1:0] rs_addr_i,
   input  logic [REG_ADDR_W-1:0] rt_addr_i,
   input  logic [REG_ADDR_W-1:0] rd_addr_i,
   input  logic [1:0]            ALUOp_i,
   input  logic [5:0]            funct_i,
   input  logic                  ALUSrc_i,
   input  logic                  RegDst_i,
   input  logic                  RegWrite_i,
   input  logic                  MemRead_i,
   input  logic                  MemWrite_i,
   input  logic                  MemtoReg_i,
   input  logic                  exmem_RegWrite_i,
   input  logic                  memwb_RegWrite_i,
   input  logic [REG_ADDR_W-1:0] exmem_rd_i,
   input  logic [REG_ADDR_W-1:0] memwb_rd_i,
   input  logic [DATA_WIDTH-1:0] exmem_data_i,
   input  logic [DATA_WIDTH-1:0] memwb_data_i,
   output logic [2:0]            ALUop_o,
   output logic [DATA_WIDTH-1:0] data_1_o,
   output logic [DATA_WIDTH-1:0] data_2_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic [REG_ADDR_W-1:0] wr_addr_o,
   output logic                  valid_o,
   output logic                  RegWrite_o,
   output logic                  MemRead_o,
   output logic                  MemWrite_o,
   output logic                  MemtoReg_o,
   output logic                  illegal_o
);

   logic [2:0]            w_alu_op;
   logic                  w_illegal;

   ctrl_t                 ctrl_q,    ctrl_d;
   logic [2:0]            alu_op_q,  alu_op_d;
   logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
   logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
   logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
   logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
   logic [DATA_WIDTH-1:0] imm_q,     imm_d;
   logic                  alu_src_q, alu_src_d;

   logic [DATA_WIDTH-1:0] w_fwd_rs;
   logic [DATA_WIDTH-1:0] w_fwd_rt;

   // ALU op decode sits on the ID side so the register holds the final code
   id_ex_stage_alu_control u_alu_control (
      .i_alu_op  (ALUOp_i),
      .i_funct   (funct_i),
      .o_alu_op  (w_alu_op),
      .o_illegal (w_illegal)
   );

   // Next-state: flush clears controls only, stall holds, otherwise load ID
   always_comb begin
      ctrl_d    = ctrl_q;
      alu_op_d  = alu_op_q;
      wr_addr_d = wr_addr_q;
      rs_addr_d = rs_addr_q;
      rt_addr_d = rt_addr_q;
      rs_data_d = rs_data_q;
      rt_data_d = rt_data_q;
      imm_d     = imm_q;
      alu_src_d = alu_src_q;
      if (flush_i) begin
         ctrl_d = '0;
      end else if (!stall_i) begin
         ctrl_d.valid      = valid_i;
         ctrl_d.reg_write  = RegWrite_i;
         ctrl_d.mem_read   = MemRead_i;
         ctrl_d.mem_write  = MemWrite_i;
         ctrl_d.mem_to_reg = MemtoReg_i;
         ctrl_d.illegal    = w_illegal & valid_i;
         alu_op_d          = w_alu_op;
         wr_addr_d         = RegDst_i ? rd_addr_i : rt_addr_i;
         rs_addr_d         = rs_addr_i;
         rt_addr_d         = rt_addr_i;
         rs_data_d         = rs_data_i;
         rt_data_d         = rt_data_i;
         imm_d             = imm_i;
         alu_src_d         = ALUSrc_i;
      end
   end

   // Pipeline register with asynchronous active-low reset
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ctrl_q    <= '0;
         alu_op_q  <= ALU_ADD;
         wr_addr_q <= '0;
         rs_addr_q <= '0;
         rt_addr_q <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         alu_src_q <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         alu_op_q  <= alu_op_d;
         wr_addr_q <= wr_addr_d;
         rs_addr_q <= rs_addr_d;
         rt_addr_q <= rt_addr_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         alu_src_q <= alu_src_d;
      end
   end

`ifdef FORWARDING_EN
   // Operand forwarding on the registered source numbers; EX/MEM is younger and wins
   always_comb begin
      w_fwd_rs = rs_data_q;
      w_fwd_rt = rt_data_q;
      if (exmem_RegWrite_i && (exmem_rd_i == rs_addr_q) && (rs_addr_q != '0)) begin
         w_fwd_rs = exmem_data_i;
      end else if (memwb_RegWrite_i && (memwb_rd_i == rs_addr_q) && (rs_addr_q != '0)) begin
         w_fwd_rs = memwb_data_i;
      end
      if (exmem_RegWrite_i && (exmem_rd_i == rt_addr_q) && (rt_addr_q != '0)) begin
         w_fwd_rt = exmem_data_i;
      end else if (memwb_RegWrite_i && (memwb_rd_i == rt_addr_q) && (rt_addr_q != '0)) begin
         w_fwd_rt = memwb_data_i;
      end
   end
`else
   // No forwarding: hazard unit stalls every RAW, so register values are current
   always_comb begin
      w_fwd_rs = rs_data_q;
      w_fwd_rt = rt_data_q;
   end

   // Forwarding-side inputs and source numbers have no consumer in this build
   logic w_unused_fwd;
   assign w_unused_fwd = ^{exmem_RegWrite_i, memwb_RegWrite_i, exmem_rd_i, memwb_rd_i,
                           exmem_data_i, memwb_data_i, rs_addr_q, rt_addr_q};
`endif

   assign data_1_o     = w_fwd_rs;
   assign store_data_o = w_fwd_rt;
   assign data_2_o     = alu_src_q ? imm_q : w_fwd_rt;

   assign ALUop_o    = alu_op_q;
   assign wr_addr_o  = wr_addr_q;
   assign valid_o    = ctrl_q.valid;
   assign RegWrite_o = ctrl_q.reg_write;
   assign MemRead_o  = ctrl_q.mem_read;
   assign MemWrite_o = ctrl_q.mem_write;
   assign MemtoReg_o = ctrl_q.mem_to_reg;
   assign illegal_o  = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Scoreboard bench for id_ex_stage. The driver applies one
//                directed vector per cycle and queues its hand-computed
//                expectation; the monitor pops one entry per falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

   typedef struct {
      logic        rstn, stall, flush, valid;
      logic [31:0] rs, rt, imm;
      logic [4:0]  rsa, rta, rda;
      logic [1:0]  aop;
      logic [5:0]  fn;
      logic        alusrc, regdst, rw, mr, mw, m2r;
      logic        xw;
      logic [4:0]  xrd;
      logic [31:0] xd;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wd;
   } in_t;

   typedef struct {
      string       name;
      logic        v, rw, mr, mw, m2r, ill;
      logic [2:0]  op;
      logic [4:0]  wr;
      logic [31:0] d1, d2, sd;
      logic        chk_data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
   logic [31:0] rs_data = '0, rt_data = '0, imm = '0;
   logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
   logic [1:0]  aluop_in = '0;
   logic [5:0]  funct = '0;
   logic        alusrc = 1'b0, regdst = 1'b0, regwrite = 1'b0;
   logic        memread = 1'b0, memwrite = 1'b0, memtoreg = 1'b0;
   logic        exmem_rw = 1'b0, memwb_rw = 1'b0;
   logic [4:0]  exmem_rd = '0, memwb_rd = '0;
   logic [31:0] exmem_data = '0, memwb_data = '0;

   logic [2:0]  alu_op;
   logic [31:0] d1, d2, sd;
   logic [4:0]  wr_addr;
   logic        v_o, rw_o, mr_o, mw_o, m2r_o, ill_o;

   int total = 0;
   int bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .stall_i          (stall),
      .flush_i          (flush),
      .valid_i          (valid),
      .rs_data_i        (rs_data),
      .rt_data_i        (rt_data),
      .imm_i            (imm),
      .rs_addr_i        (rs_addr),
      .rt_addr_i        (rt_addr),
      .rd_addr_i        (rd_addr),
      .ALUOp_i          (aluop_in),
      .funct_i          (funct),
      .ALUSrc_i         (alusrc),
      .RegDst_i         (regdst),
      .RegWrite_i       (regwrite),
      .MemRead_i        (memread),
      .MemWrite_i       (memwrite),
      .MemtoReg_i       (memtoreg),
      .exmem_RegWrite_i (exmem_rw),
      .memwb_RegWrite_i (memwb_rw),
      .exmem_rd_i       (exmem_rd),
      .memwb_rd_i       (memwb_rd),
      .exmem_data_i     (exmem_data),
      .memwb_data_i     (memwb_data),
      .ALUop_o          (alu_op),
      .data_1_o         (d1),
      .data_2_o         (d2),
      .store_data_o     (sd),
      .wr_addr_o        (wr_addr),
      .valid_o          (v_o),
      .RegWrite_o       (rw_o),
      .MemRead_o        (mr_o),
      .MemWrite_o       (mw_o),
      .MemtoReg_o       (m2r_o),
      .illegal_o        (ill_o)
   );

   // Forwarded value when the feature is built in, plain register value otherwise
   function automatic logic [31:0] pick(input logic [31:0] f, input logic [31:0] n);
`ifdef FORWARDING_EN
      return f;
`else
      return n;
`endif
   endfunction

   function automatic in_t idle();
      in_t s;
      s.rstn = 1'b1; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b0;
      s.rs = '0; s.rt = '0; s.imm = '0;
      s.rsa = '0; s.rta = '0; s.rda = '0;
      s.aop = '0; s.fn = '0;
      s.alusrc = 1'b0; s.regdst = 1'b0; s.rw = 1'b0; s.mr = 1'b0; s.mw = 1'b0; s.m2r = 1'b0;
      s.xw = 1'b0; s.xrd = '0; s.xd = '0;
      s.ww = 1'b0; s.wrd = '0; s.wd = '0;
      return s;
   endfunction

   function automatic exp_t mk(input string n, input logic v, input logic rw, input logic mr,
                               input logic mw, input logic m2r, input logic ill,
                               input logic [2:0] op, input logic [4:0] wr,
                               input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] es);
      exp_t e;
      e.name = n; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r; e.ill = ill;
      e.op = op; e.wr = wr; e.d1 = e1; e.d2 = e2; e.sd = es; e.chk_data = 1'b1;
      return e;
   endfunction

   // Bubble: only the control bits are defined
   function automatic exp_t bubble(input string n);
      exp_t e;
      e = mk(n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, '0, '0, '0);
      e.chk_data = 1'b0;
      return e;
   endfunction

   // Apply one vector just after a falling edge and queue what the next falling edge must show
   task automatic go(input in_t s, input exp_t e);
      rst_n = s.rstn; stall = s.stall; flush = s.flush; valid = s.valid;
      rs_data = s.rs; rt_data = s.rt; imm = s.imm;
      rs_addr = s.rsa; rt_addr = s.rta; rd_addr = s.rda;
      aluop_in = s.aop; funct = s.fn;
      alusrc = s.alusrc; regdst = s.regdst; regwrite = s.rw;
      memread = s.mr; memwrite = s.mw; memtoreg = s.m2r;
      exmem_rw = s.xw; exmem_rd = s.xrd; exmem_data = s.xd;
      memwb_rw = s.ww; memwb_rd = s.wrd; memwb_data = s.wd;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   // Monitor: one expectation per falling edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic ok;
         e  = sb.pop_front();
         ok = (v_o === e.v) && (rw_o === e.rw) && (mr_o === e.mr) && (mw_o === e.mw) &&
              (m2r_o === e.m2r) && (ill_o === e.ill);
         if (e.chk_data)
            ok = ok && (alu_op === e.op) && (wr_addr === e.wr) &&
                 (d1 === e.d1) && (d2 === e.d2) && (sd === e.sd);
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL %s: got v=%b rw=%b mr=%b mw=%b m2r=%b ill=%b op=%b wr=%0d d1=%h d2=%h sd=%h want v=%b rw=%b mr=%b mw=%b m2r=%b ill=%b op=%b wr=%0d d1=%h d2=%h sd=%h data_checked=%b",
                     e.name, v_o, rw_o, mr_o, mw_o, m2r_o, ill_o, alu_op, wr_addr, d1, d2, sd,
                     e.v, e.rw, e.mr, e.mw, e.m2r, e.ill, e.op, e.wr, e.d1, e.d2, e.sd, e.chk_data);
         end
      end
   end

   // Directed stimulus
   initial begin
      in_t s;
      logic [5:0] fns [4];
      logic [2:0] ops [4];
      fns[0] = 6'b011000; ops[0] = 3'b011;
      fns[1] = 6'b100100; ops[1] = 3'b000;
      fns[2] = 6'b100101; ops[2] = 3'b001;
      fns[3] = 6'b100000; ops[3] = 3'b010;

      @(negedge clk);
      #1;

      // Reset held with a live instruction on the ID side
      s = idle(); s.rstn = 1'b0; s.valid = 1'b1; s.rw = 1'b1; s.aop = 2'b10; s.fn = 6'b100010;
      go(s, mk("reset0", 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));
      go(s, mk("reset1", 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));

      // R-type SUB, RegDst picks rd
      s = idle(); s.valid = 1; s.aop = 2'b10; s.fn = 6'b100010; s.rw = 1; s.regdst = 1;
      s.rs = 32'h11; s.rt = 32'h22; s.rsa = 1; s.rta = 2; s.rda = 3;
      go(s, mk("dec_sub", 1, 1, 0, 0, 0, 0, 3'b110, 3, 32'h11, 32'h22, 32'h22));

      // Unsupported funct -> ADD + illegal, RegDst=0 picks rt
      s = idle(); s.valid = 1; s.aop = 2'b10; s.fn = 6'b000111; s.rta = 7; s.rs = 5; s.rt = 6;
      go(s, mk("dec_illegal", 1, 0, 0, 0, 0, 1, 3'b010, 7, 5, 6, 6));

      // Load-style: ALUOp 00, immediate operand
      s = idle(); s.valid = 1; s.aop = 2'b00; s.mr = 1; s.m2r = 1; s.rw = 1; s.alusrc = 1;
      s.imm = 32'h8; s.rs = 32'h100; s.rsa = 4; s.rt = 32'h33; s.rta = 9;
      go(s, mk("aluop00", 1, 1, 1, 0, 1, 0, 3'b010, 9, 32'h100, 32'h8, 32'h33));

      // Branch-style: ALUOp 01 -> SUB
      s = idle(); s.valid = 1; s.aop = 2'b01; s.mw = 1; s.rs = 32'h50; s.rt = 32'h20; s.rta = 2;
      go(s, mk("aluop01", 1, 0, 0, 1, 0, 0, 3'b110, 2, 32'h50, 32'h20, 32'h20));

      // ALUOp 11 -> OR
      s = idle(); s.valid = 1; s.aop = 2'b11; s.rw = 1; s.rs = 32'hF0; s.rt = 32'h0F; s.rta = 4;
      go(s, mk("aluop11", 1, 1, 0, 0, 0, 0, 3'b001, 4, 32'hF0, 32'h0F, 32'h0F));

      // Remaining supported funct codes
      for (int k = 0; k < 4; k++) begin
         s = idle(); s.valid = 1; s.aop = 2'b10; s.fn = fns[k]; s.rw = 1; s.regdst = 1; s.rda = 8;
         s.rs = 32'h1; s.rt = 32'h2;
         go(s, mk($sformatf("funct%0d", k), 1, 1, 0, 0, 0, 0, ops[k], 8, 32'h1, 32'h2, 32'h2));
      end

      // Bad funct with no real instruction: illegal stays low
      s = idle(); s.aop = 2'b10; s.fn = 6'b111111;
      go(s, mk("illegal_novalid", 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));

      // Forwarding priority on rs
      s = idle(); s.valid = 1; s.rw = 1; s.rsa = 5; s.rs = 32'h1234; s.rta = 1; s.rt = 32'h77;
      s.xw = 1; s.xrd = 5; s.xd = 32'hAAAA; s.ww = 1; s.wrd = 5; s.wd = 32'hBBBB;
      go(s, mk("fwd_both", 1, 1, 0, 0, 0, 0, 3'b010, 1, pick(32'hAAAA, 32'h1234), 32'h77, 32'h77));
      s.xw = 0;
      go(s, mk("fwd_memwb", 1, 1, 0, 0, 0, 0, 3'b010, 1, pick(32'hBBBB, 32'h1234), 32'h77, 32'h77));
      s.rsa = 0; s.rs = 32'h5555; s.xw = 1; s.xrd = 0; s.wrd = 0;
      go(s, mk("fwd_r0", 1, 1, 0, 0, 0, 0, 3'b010, 1, 32'h5555, 32'h77, 32'h77));

      // ALUSrc selects imm while store data still sees the forwarded rt
      s = idle(); s.valid = 1; s.rw = 1; s.alusrc = 1; s.imm = 32'hFFFF_FFFC;
      s.rsa = 1; s.rs = 32'h7; s.rta = 6; s.rt = 32'h99; s.xw = 1; s.xrd = 6; s.xd = 32'h10;
      go(s, mk("alusrc", 1, 1, 0, 0, 0, 0, 3'b010, 6, 32'h7, 32'hFFFF_FFFC, pick(32'h10, 32'h99)));
      s.alusrc = 0; s.xrd = 7; s.ww = 1; s.wrd = 6; s.wd = 32'h20;
      go(s, mk("fwd_rt_memwb", 1, 1, 0, 0, 0, 0, 3'b010, 6, 32'h7, pick(32'h20, 32'h99), pick(32'h20, 32'h99)));

      // Load a known state, then stall three cycles with changing inputs
      s = idle(); s.valid = 1; s.mw = 1; s.aop = 2'b01; s.rs = 32'hA1; s.rsa = 2; s.rt = 32'hB2; s.rta = 3;
      go(s, mk("pre_stall", 1, 0, 0, 1, 0, 0, 3'b110, 3, 32'hA1, 32'hB2, 32'hB2));
      for (int k = 0; k < 3; k++) begin
         s = idle(); s.stall = 1; s.valid = k[0]; s.aop = 2'b11; s.rw = 1; s.mr = 1;
         s.rs = 32'h1000 + k; s.rt = 32'h2000 + k; s.rsa = 5'(k + 10); s.rta = 5'(k + 20); s.imm = 32'hDEAD;
         go(s, mk($sformatf("stall%0d", k), 1, 0, 0, 1, 0, 0, 3'b110, 3, 32'hA1, 32'hB2, 32'hB2));
      end

      // Stall and flush together: bubble
      s = idle(); s.stall = 1; s.flush = 1; s.valid = 1; s.mw = 1; s.rw = 1;
      go(s, bubble("stall_flush"));

      // Reload, then flush alone
      s = idle(); s.valid = 1; s.rw = 1; s.m2r = 1; s.mr = 1; s.aop = 2'b11; s.rs = 32'h3; s.rt = 32'h4; s.rta = 5;
      go(s, mk("reload", 1, 1, 1, 0, 1, 0, 3'b001, 5, 32'h3, 32'h4, 32'h4));
      s.flush = 1;
      go(s, bubble("flush"));

      // Reload, then reset asserted during a stall
      s = idle(); s.valid = 1; s.rw = 1; s.aop = 2'b01; s.rs = 32'h9; s.rt = 32'hA; s.rta = 11;
      go(s, mk("reload2", 1, 1, 0, 0, 0, 0, 3'b110, 11, 32'h9, 32'hA, 32'hA));
      s = idle(); s.rstn = 0; s.stall = 1; s.valid = 1; s.rw = 1;
      go(s, mk("reset_stall", 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));
      s.rstn = 1; s.aop = 2'b01;
      go(s, mk("stall_after_reset", 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));

      // Normal load after reset
      s = idle(); s.valid = 1; s.rw = 1; s.aop = 2'b10; s.fn = 6'b011000; s.regdst = 1; s.rda = 31;
      s.rs = 32'hCAFE; s.rt = 32'hBEEF;
      go(s, mk("final_mul", 1, 1, 0, 0, 0, 0, 3'b011, 31, 32'hCAFE, 32'hBEEF, 32'hBEEF));

      // Every queued expectation must have been consumed
      @(negedge clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d entries left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
